gpio_bus_arbiter: RTL and testbench
===================================

// Module: gpio_bus_arbiter
// PURPOSE
//   Shares the single gpio register interface (3-bit addr, wr_en, wr_data, comb. rd_data)
//   among NREQ requesters (CPU, bit-bang engine, debug port). Round-robin arbitration,
//   one registered access per grant, per-requester ack pulse with captured read data.
//   Sits between the requesters and the gpio block; the gpio block sees one master.
// PARAMETERS
//   NREQ  2  number of requesters, legal range 2..8
// PORTS
//   clk           in   1        system clock
//   rst_n         in   1        synchronous reset, active low
//   req           in   NREQ     per-requester access request, level
//   req_we        in   NREQ     1=write, 0=read
//   req_addr      in   3*NREQ   register address, requester i at [3i+2:3i]
//   req_wdata     in   8*NREQ   write data, requester i at [8i+7:8i]
//   req_lock      in   NREQ     hold ownership after this access (used only with GPIO_ARB_LOCK_EN)
//   ack           out  NREQ     one-cycle completion pulse to owner
//   rsp_rdata     out  8        read data, valid in ack cycle, held until next ack
//   busy          out  1        high in ACCESS/DONE
//   owner         out  3        index of current/last granted requester
//   gpio_addr     out  3        to gpio addr
//   gpio_wr_en    out  1        to gpio wr_en
//   gpio_wr_data  out  8        to gpio wr_data
//   gpio_rd_data  in   8        from gpio rd_data (combinational)
// BEHAVIOUR
// - Reset (rst_n low at posedge): state=IDLE, ack=0, rsp_rdata=0, busy=0, owner=0,
//   rr pointer last=NREQ-1 (requester 0 wins first), lock flag clear, latched cmd=0.
// - gpio_wr_en = (state==ACCESS) & latched_we & rst_n; gated by rst_n so no write in reset.
// - gpio_addr/gpio_wr_data driven from latched cmd; 0 outside ACCESS.
// - FSM IDLE -> ACCESS -> DONE -> IDLE, one access per 3 cycles max:
//   IDLE: if any eligible req, winner = first set bit searching last+1, last+2, ... mod NREQ.
//         Latch winner's we/addr/wdata, owner<=winner, go ACCESS. Else stay.
//   ACCESS: gpio bus driven for exactly one cycle; rsp_rdata<=gpio_rd_data at the edge
//         ending ACCESS on reads; unchanged on writes. Go DONE.
//   DONE: ack[owner]=1 for this cycle only; last<=owner; go IDLE.
// - Latency: req sampled high in IDLE cycle N -> gpio access cycle N+1 -> ack cycle N+2.
// - Requester holds req/we/addr/wdata stable until ack; drops req at the ack edge.
//   req still high in the IDLE after ack = new request (arbitrated normally).
// - req dropped before ack: access still completes, ack still pulses; no abort.
// - Simultaneous requests: strict round robin; a continuously requesting set is served in
//   rotating order, no requester waits more than NREQ-1 grants.
// - Reads have no side effects in gpio; addr=0 idle value is harmless.
// - Only one ack bit high at any time; ack never high outside DONE.
// - Reset mid-operation: at any state, next state IDLE, ack not issued, access dropped.
// CONFIGURATION
// - GPIO_ARB_LOCK_EN defined: in DONE, if req_lock[owner]=1, set lock flag (lock_owner=owner).
//   While lock flag set, IDLE considers only lock_owner's req; others wait. Flag clears
//   at DONE of an access with req_lock[owner]=0, or in IDLE when req_lock[lock_owner]=0 and
//   req[lock_owner]=0 (arbitration resumes that cycle). Enables atomic read-modify-write.
// - GPIO_ARB_LOCK_EN undefined: req_lock ignored, no lock flag logic, pure round robin.
// TESTING
// 1. NREQ=2, req[0] write addr=1 wdata=8'hFF -> cycle+1 gpio_wr_en=1 addr=1 data=FF, one cycle; cycle+2 ack=2'b01.
// 2. req[1] read addr=4, gpio_rd_data=8'h03 -> ack=2'b10 with rsp_rdata=8'h03; rsp_rdata holds after.
// 3. After reset req=2'b11 held (re-raised after each ack) -> grant order 0,1,0,1; ack every 3 cycles.
// 4. LOCK_EN: req[0] lock=1 read addr 0 then write addr 0 lock=0, req[1] pending throughout ->
//    both req[0] acks precede req[1] ack; without LOCK_EN req[1] served between them.
// 5. rst_n low during ACCESS of a write -> gpio_wr_en=0 that cycle, no ack, IDLE, owner=0.
// 6. NREQ=3, last=1, req=3'b101 -> requester 2 wins, then 0.

Source files
------------

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares the single gpio register port among NREQ requesters.
// Round-robin arbitration, one registered access per grant, ack pulse to the owner.
// Optional feature macro: GPIO_ARB_LOCK_EN (owner may hold the bus across accesses).
//
//   state  | meaning
//   IDLE   | arbitrate among eligible requesters, latch the winner's command
//   ACCESS | drive the gpio bus for one cycle, capture read data
//   DONE   | pulse ack to the owner, advance the round-robin pointer
module gpio_bus_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [3*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic [2:0]        owner,
  output logic [2:0]        gpio_addr,
  output logic              gpio_wr_en,
  output logic [7:0]        gpio_wr_data,
  input  logic [7:0]        gpio_rd_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nx;
  logic [2:0]      last;
  logic [2:0]      owner_q;
  logic            cmd_we;
  logic [2:0]      cmd_addr;
  logic [7:0]      cmd_wdata;
  logic [7:0]      rdata_q;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] owner_1h;
  logic            grant_vld;
  logic [2:0]      grant_idx;
  logic            sel_we;
  logic [2:0]      sel_addr;
  logic [7:0]      sel_wdata;

  assign owner     = owner_q;
  assign rsp_rdata = rdata_q;

`ifdef GPIO_ARB_LOCK_EN
  logic       lock_q;
  logic [2:0] lock_owner;
  logic       lock_req;
  logic       lock_hold;
  logic       lock_release;
  logic       owner_lock;

  // While locked only the lock owner may win; releases once it idles without lock
  always_comb begin
    lock_req   = 1'b0;
    lock_hold  = 1'b0;
    owner_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (lock_owner == 3'(i)) begin
        lock_req  = req[i];
        lock_hold = req_lock[i];
      end
      if (owner_q == 3'(i)) owner_lock = req_lock[i];
    end
    lock_release = lock_q & ~lock_req & ~lock_hold;
    eligible     = req;
    if (lock_q && !lock_release) begin
      for (int i = 0; i < NREQ; i++) eligible[i] = req[i] & (lock_owner == 3'(i));
    end
  end

  // Lock flag follows req_lock of the owner at completion, drops on release in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_owner <= '0;
    end else if (state == DONE) begin
      lock_q     <= owner_lock;
      lock_owner <= owner_q;
    end else if (state == IDLE && lock_release) begin
      lock_q <= 1'b0;
    end
  end
`else
  logic unused_req_lock;
  assign unused_req_lock = ^req_lock;
  assign eligible        = req;
`endif

  // Round robin: first eligible requester searching upward from last+1
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_vld && eligible[i] && (i == (int'(last) + k) % NREQ)) begin
          grant_vld = 1'b1;
          grant_idx = 3'(i);
        end
      end
    end
  end

  // Owner decode and selection of the winner's command fields
  always_comb begin
    owner_1h  = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_1h[i] = (owner_q == 3'(i));
      if (grant_idx == 3'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[3*i +: 3];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  // Next state and bus/ack outputs; write enable and ack are suppressed during reset
  always_comb begin
    state_nx     = state;
    ack          = '0;
    busy         = 1'b0;
    gpio_addr    = '0;
    gpio_wr_en   = 1'b0;
    gpio_wr_data = '0;
    case (state)
      IDLE: begin
        if (grant_vld) state_nx = ACCESS;
      end
      ACCESS: begin
        busy         = 1'b1;
        gpio_addr    = cmd_addr;
        gpio_wr_data = cmd_wdata;
        gpio_wr_en   = cmd_we & rst_n;
        state_nx     = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        ack      = owner_1h & {NREQ{rst_n}};
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Command latch, read capture, owner and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last      <= 3'(NREQ - 1);
      owner_q   <= '0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            cmd_we    <= sel_we;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            owner_q   <= grant_idx;
          end
        end
        ACCESS: begin
          if (!cmd_we) rdata_q <= gpio_rd_data;
        end
        DONE: last <= owner_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed scenarios plus randomized requester traffic, checked
// against a transaction-timing reference model of the arbiter and a gpio register file.
module tb_gpio_bus_arbiter;
  localparam int N = 3;

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       lock;
  } cmd_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_we = '0;
  logic [3*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N-1:0]   ack;
  logic [7:0]     rsp_rdata;
  logic           busy;
  logic [2:0]     owner;
  logic [2:0]     gpio_addr;
  logic           gpio_wr_en;
  logic [7:0]     gpio_wr_data;
  logic [7:0]     gpio_rd_data;

  logic [7:0] slave_mem [8];
  logic [7:0] exp_mem [8];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rand_mode = 0;
  logic rst_next = 1'b0;

  cmd_t         cmdq [N][$];
  logic [N-1:0] ack_prev = '0;
  logic [N-1:0] dropped = '0;
  int           ack_log[$];
  int           ack_cyc[$];

  // reference model: a granted access occupies the two cycles after its grant
  bit         m_busy;
  int         m_t;
  int         m_idx;
  cmd_t       m_cmd;
  int         m_last;
  int         m_owner;
  logic [7:0] m_rdata;
  bit         m_lock;
  int         m_lock_owner;

  gpio_bus_arbiter #(.NREQ(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_lock(req_lock), .ack(ack), .rsp_rdata(rsp_rdata),
    .busy(busy), .owner(owner), .gpio_addr(gpio_addr), .gpio_wr_en(gpio_wr_en),
    .gpio_wr_data(gpio_wr_data), .gpio_rd_data(gpio_rd_data)
  );

  always #5 clk = ~clk;
  assign gpio_rd_data = slave_mem[gpio_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we    = 1'($urandom_range(0, 1));
    c.addr  = 3'($urandom_range(0, 7));
    c.wdata = 8'($urandom_range(0, 255));
    c.lock  = ($urandom_range(0, 3) == 0);
    return c;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_t = -10; m_idx = 0; m_cmd = '0; m_last = N - 1; m_owner = 0;
    m_rdata = 8'h00; m_lock = 0; m_lock_owner = 0;
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (cmdq[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drive();
    cmd_t c;
    rst_n = rand_mode ? ($urandom_range(0, 399) != 0) : rst_next;
    for (int i = 0; i < N; i++) begin
      if (bit_at(ack_prev, i) && cmdq[i].size() > 0) begin
        void'(cmdq[i].pop_front());
        dropped[i] = 1'b0;
      end
      if (rand_mode && cmdq[i].size() < 2 && $urandom_range(0, 3) == 0)
        cmdq[i].push_back(rand_cmd());
    end
    if (rand_mode && m_busy && cyc == m_t + 1 && $urandom_range(0, 5) == 0)
      dropped = dropped | (N'(1) << m_idx);
    if (!rst_n) dropped = '0;
    for (int i = 0; i < N; i++) begin
      if (cmdq[i].size() > 0 && !bit_at(dropped, i)) begin
        c = cmdq[i][0];
        req[i] = 1'b1;
        req_we[i] = c.we;
        req_addr[3*i +: 3] = c.addr;
        req_wdata[8*i +: 8] = c.wdata;
        req_lock[i] = c.lock;
      end else begin
        req[i] = 1'b0;
        req_lock[i] = 1'b0;
      end
    end
  endtask

  task automatic check_and_advance();
    logic [N-1:0] e_ack, elig;
    bit e_acc, e_done;
    int best, bestd, d;
    e_acc  = m_busy && (cyc == m_t + 1);
    e_done = m_busy && (cyc == m_t + 2);
    e_ack  = (e_done && rst_n) ? (N'(1) << m_idx) : '0;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_acc || e_done));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("gpio_wr_en", 32'(gpio_wr_en), 32'(e_acc && m_cmd.we && rst_n));
    chk("gpio_addr", 32'(gpio_addr), e_acc ? 32'(m_cmd.addr) : 32'd0);
    chk("gpio_wr_data", 32'(gpio_wr_data), e_acc ? 32'(m_cmd.wdata) : 32'd0);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));

    ack_prev = ack;
    for (int i = 0; i < N; i++) if (bit_at(ack, i)) begin ack_log.push_back(i); ack_cyc.push_back(cyc); end
    if (gpio_wr_en) slave_mem[gpio_addr] = gpio_wr_data;

    if (!rst_n) begin
      model_reset();
    end else if (e_acc) begin
      if (m_cmd.we) exp_mem[m_cmd.addr] = m_cmd.wdata;
      else          m_rdata = exp_mem[m_cmd.addr];
    end else if (e_done) begin
      m_last = m_idx;
      m_busy = 0;
`ifdef GPIO_ARB_LOCK_EN
      m_lock = bit_at(req_lock, m_idx);
      m_lock_owner = m_idx;
`endif
    end else if (!m_busy) begin
      elig = req;
`ifdef GPIO_ARB_LOCK_EN
      if (m_lock) begin
        if (!bit_at(req, m_lock_owner) && !bit_at(req_lock, m_lock_owner)) m_lock = 0;
        else elig = req & (N'(1) << m_lock_owner);
      end
`endif
      best = -1; bestd = N;
      for (int i = 0; i < N; i++) begin
        if (bit_at(elig, i)) begin
          d = (i - m_last - 1 + 2 * N) % N;
          if (d < bestd) begin bestd = d; best = i; end
        end
      end
      if (best >= 0) begin
        m_busy = 1; m_t = cyc; m_idx = best; m_owner = best;
        m_cmd.we    = bit_at(req_we, best);
        m_cmd.addr  = 3'(req_addr >> (3 * best));
        m_cmd.wdata = 8'(req_wdata >> (8 * best));
        m_cmd.lock  = bit_at(req_lock, best);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    drive();
    #1;
    check_and_advance();
  endtask

  task automatic drain(input int max);
    int n = 0;
    do begin tick(); n++; end while ((pending() || m_busy) && n < max);
    if (pending() || m_busy) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst_next = 1'b0; tick(); tick();
    rst_next = 1'b1;
  endtask

  function automatic cmd_t mk(input logic we, input logic [2:0] a, input logic [7:0] wd, input logic lk);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = wd; c.lock = lk;
    return c;
  endfunction

  initial begin
    for (int a = 0; a < 8; a++) begin
      slave_mem[a] = 8'(a * 17 + 5);
      exp_mem[a]   = 8'(a * 17 + 5);
    end
    slave_mem[4] = 8'h03; exp_mem[4] = 8'h03;
    model_reset();

    do_reset();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    tick();

    // single write from requester 0
    cmdq[0].push_back(mk(1'b1, 3'd1, 8'hFF, 1'b0));
    tick();
    tick();
    chk("t1_wr_en", 32'(gpio_wr_en), 32'd1);
    chk("t1_addr", 32'(gpio_addr), 32'd1);
    chk("t1_wdata", 32'(gpio_wr_data), 32'hFF);
    tick();
    chk("t1_ack", 32'(ack), 32'b001);
    tick();
    chk("t1_wr_en_off", 32'(gpio_wr_en), 32'd0);
    chk("t1_ack_off", 32'(ack), 32'd0);

    // read from requester 1
    cmdq[1].push_back(mk(1'b0, 3'd4, 8'h00, 1'b0));
    tick(); tick(); tick();
    chk("t2_ack", 32'(ack), 32'b010);
    chk("t2_rdata", 32'(rsp_rdata), 32'h03);
    tick(); tick();
    chk("t2_rdata_hold", 32'(rsp_rdata), 32'h03);

    // two requesters held continuously alternate, one ack every 3 cycles
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cmdq[0].push_back(mk(1'b0, 3'(k), 8'h00, 1'b0));
      cmdq[1].push_back(mk(1'b0, 3'(k + 4), 8'h00, 1'b0));
    end
    ack_log.delete(); ack_cyc.delete();
    drain(60);
    chk("t3_count", 32'(ack_log.size()), 32'd8);
    for (int k = 0; k < 4; k++) chk("t3_order", 32'(ack_log[k]), 32'(k % 2));
    chk("t3_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);

    // locked read-modify-write against a competing requester
    do_reset();
    cmdq[0].push_back(mk(1'b0, 3'd0, 8'h00, 1'b1));
    cmdq[0].push_back(mk(1'b1, 3'd0, 8'h5A, 1'b0));
    cmdq[1].push_back(mk(1'b0, 3'd2, 8'h00, 1'b0));
    ack_log.delete(); ack_cyc.delete();
    drain(60);
    chk("t4_count", 32'(ack_log.size()), 32'd3);
`ifdef GPIO_ARB_LOCK_EN
    chk("t4_second", 32'(ack_log[1]), 32'd0);
    chk("t4_third", 32'(ack_log[2]), 32'd1);
`else
    chk("t4_second", 32'(ack_log[1]), 32'd1);
    chk("t4_third", 32'(ack_log[2]), 32'd0);
`endif

    // reset asserted during the ACCESS cycle of a write
    do_reset();
    cmdq[0].push_back(mk(1'b1, 3'd3, 8'h77, 1'b0));
    tick();
    rst_next = 1'b0;
    tick();
    chk("t5_wr_en", 32'(gpio_wr_en), 32'd0);
    cmdq[0].delete();
    rst_next = 1'b1;
    tick();
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_owner", 32'(owner), 32'd0);
    chk("t5_nowrite", 32'(slave_mem[3]), 32'(8'd56));
    tick();
    chk("t5_noack_late", 32'(ack), 32'd0);

    // last=1, requesters 0 and 2 together: 2 first, then 0
    do_reset();
    cmdq[1].push_back(mk(1'b0, 3'd5, 8'h00, 1'b0));
    drain(30);
    cmdq[0].push_back(mk(1'b0, 3'd6, 8'h00, 1'b0));
    cmdq[2].push_back(mk(1'b1, 3'd7, 8'hC3, 1'b0));
    ack_log.delete(); ack_cyc.delete();
    drain(30);
    chk("t6_count", 32'(ack_log.size()), 32'd2);
    chk("t6_first", 32'(ack_log[0]), 32'd2);
    chk("t6_second", 32'(ack_log[1]), 32'd0);

    // randomized traffic with occasional early drops and resets
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
